engine_scheduler: RTL

- Sequences a frame's pixel coordinates across N Mandelbrot iteration engines in strict round-robin order.
- Collects their iteration-count results in the same order, so output emerges in raster order.
- Presents results as a pixel stream with valid/ready, sof and eol, ready for the colour-mapping/AXI-stream packer.
- Sits between the pixel_generator stream logic and the engine array.

---
 rtl/engine_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/engine_scheduler.sv
// Round-robin job dispatcher and in-order result collector for an array of
// Mandelbrot iteration engines, emitting iteration counts as a raster pixel stream.
module engine_scheduler #(
    parameter int N_ENGINES = 4,
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int COORD_W   = 11,
    parameter int ITER_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    output logic                          busy,
    input  logic [N_ENGINES-1:0]          eng_idle,
    output logic [N_ENGINES-1:0]          eng_start,
    output logic [COORD_W-1:0]            eng_x,
    output logic [COORD_W-1:0]            eng_y,
    input  logic [N_ENGINES-1:0]          eng_done,
    input  logic [N_ENGINES*ITER_W-1:0]   eng_iter,
    output logic [N_ENGINES-1:0]          eng_ack,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ITER_W-1:0]             out_iter,
    output logic [COORD_W-1:0]            out_x,
    output logic [COORD_W-1:0]            out_y,
    output logic                          out_sof,
    output logic                          out_eol
);

    localparam int PTR_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(N_ENGINES - 1);
    localparam logic [COORD_W-1:0] LAST_X   = COORD_W'(X_SIZE - 1);
    localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(Y_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       dptr;
    logic [PTR_W-1:0]       cptr;
    logic [N_ENGINES-1:0]   pending;
    logic [N_ENGINES-1:0]   pending_nxt;
    logic [N_ENGINES-1:0]   issue_mask;
    logic [N_ENGINES-1:0]   collect_mask;
    logic [COORD_W-1:0]     dx;
    logic [COORD_W-1:0]     dy;
    logic [COORD_W-1:0]     cx;
    logic [COORD_W-1:0]     cy;
    logic                   issue;
    logic                   collect;
    logic                   frame_end;

    function automatic logic [N_ENGINES-1:0] onehot(input logic [PTR_W-1:0] p);
        logic [N_ENGINES-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Pending gating keeps issue and collect on disjoint engines in any cycle.
    always_comb begin
        issue        = (state == DISPATCH) && eng_idle[dptr] && !pending[dptr];
        collect      = pending[cptr] && eng_done[cptr] && (!out_valid || out_ready);
        issue_mask   = issue   ? onehot(dptr) : '0;
        collect_mask = collect ? onehot(cptr) : '0;
        pending_nxt  = (pending | issue_mask) & ~collect_mask;
        frame_end    = issue && (dx == LAST_X) && (dy == LAST_Y);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dptr      <= '0;
            cptr      <= '0;
            pending   <= '0;
            dx        <= '0;
            dy        <= '0;
            cx        <= '0;
            cy        <= '0;
            eng_start <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
            eng_ack   <= '0;
            out_valid <= 1'b0;
            out_iter  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            pending   <= pending_nxt;
            eng_start <= issue_mask;
            eng_ack   <= collect_mask;

            case (state)
                IDLE:     if (run) state <= DISPATCH;
                DISPATCH: if (frame_end && !run) state <= DRAIN;
                DRAIN:    if (pending_nxt == '0) state <= IDLE;
                default:  state <= IDLE;
            endcase

            if (issue) begin
                eng_x <= dx;
                eng_y <= dy;
                dptr  <= next_ptr(dptr);
                if (dx == LAST_X) begin
                    dx <= '0;
                    dy <= (dy == LAST_Y) ? '0 : dy + 1'b1;
                end else begin
                    dx <= dx + 1'b1;
                end
            end

            // Output register doubles as the stream skid: it only reloads when free.
            if (collect) begin
                out_valid <= 1'b1;
                out_iter  <= eng_iter[int'(cptr)*ITER_W +: ITER_W];
                out_x     <= cx;
                out_y     <= cy;
                out_sof   <= (cx == '0) && (cy == '0);
                out_eol   <= (cx == LAST_X);
                cptr      <= next_ptr(cptr);
                if (cx == LAST_X) begin
                    cx <= '0;
                    cy <= (cy == LAST_Y) ? '0 : cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
